// File: rtl/bcd_result_fix.sv
// bcd_result_fix: collects a DIGITS-digit BCD sum packet and applies the 9's-complement end-around fix.
// Optional BCD_FIX_ZERO_CLEAN_EN forces a zero magnitude to a positive sign.
module bcd_result_fix #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_digit,
    input  logic                in_cout,
    input  logic                in_last,
    input  logic                in_sub,
    input  logic                in_sign,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_mag,
    output logic                out_sign,
    output logic                out_ovf,
    output logic                out_err
);
    typedef enum logic [1:0] {COLLECT, FIX, OUT} state_t;
    localparam int CW = $clog2(DIGITS);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [3:0] dig [DIGITS];
    logic cy, sub, sgn, inc, rdy, err, ovf, osign;
    logic last, xfer, others_zero, sign_n;
    logic [3:0] d, fixd;
    assign last = cnt == CW'(DIGITS - 1);
    assign xfer = in_valid & rdy;
    assign d = dig[cnt];
    assign in_ready = rdy;
    assign out_valid = state == OUT;
    assign out_sign = osign;
    assign out_ovf = ovf;
    assign out_err = err;
    for (genvar g = 0; g < DIGITS; g++) begin : g_mag
        assign out_mag[4*g +: 4] = dig[g];
    end
    always_comb begin
        fixd = !sub ? d : !cy ? 4'd9 - d : (inc && d == 4'd9) ? 4'd0 : d + {3'b000, inc};
        others_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (CW'(i) != cnt && dig[i] != 4'd0) others_zero = 1'b0;
`ifdef BCD_FIX_ZERO_CLEAN_EN
        sign_n = (fixd == 4'd0 && others_zero) ? 1'b0 : (sub & ~cy) ? ~sgn : sgn;
`else
        sign_n = (sub & ~cy) ? ~sgn : sgn;
`endif
    end
    always_comb begin
        state_n = state;
        case (state)
            COLLECT: state_n = (xfer && last) ? FIX : COLLECT;
            FIX:     state_n = last ? OUT : FIX;
            OUT:     state_n = out_ready ? COLLECT : OUT;
            default: state_n = COLLECT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            cnt   <= '0;
            for (int i = 0; i < DIGITS; i++) dig[i] <= 4'd0;
            {cy, sub, sgn, inc, rdy, err, ovf, osign} <= '0;
        end else begin
            state <= state_n;
            rdy   <= state_n == COLLECT;
            case (state)
                COLLECT: if (xfer) begin
                    dig[cnt] <= in_digit;
                    if (cnt == '0) {sub, sgn} <= {in_sub, in_sign};
                    if (in_last != last) err <= 1'b1;
                    if (last) begin
                        cy  <= in_cout;
                        inc <= 1'b1;
                        cnt <= '0;
                    end else cnt <= cnt + 1'b1;
                end
                FIX: begin
                    dig[cnt] <= fixd;
                    // increment keeps rippling only through a run of 9s
                    inc <= inc & (d == 4'd9);
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        osign <= sign_n;
                        ovf   <= ~sub & cy;
                    end
                end
                OUT: if (out_ready) begin
                    cnt <= '0;
                    err <= 1'b0;
                    ovf <= 1'b0;
                end
                default: cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_result_fix.sv
// tb_bcd_result_fix: directed vectors for bcd_result_fix with DIGITS=4.
module tb_bcd_result_fix;
    logic clk = 0, rst = 1;
    logic in_valid = 0, in_ready, in_cout = 0, in_last = 0, in_sub = 0, in_sign = 0;
    logic [3:0] in_digit = 0;
    logic out_valid, out_ready = 0, out_sign, out_ovf, out_err;
    logic [15:0] out_mag;
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    bcd_result_fix #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit),
        .in_cout(in_cout), .in_last(in_last), .in_sub(in_sub), .in_sign(in_sign),
        .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag), .out_sign(out_sign),
        .out_ovf(out_ovf), .out_err(out_err)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [15:0] s, input logic c, input logic sb, input logic sg, input int lastpos);
        check("rdy_before_pkt", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            in_digit = s[4*i +: 4];
            in_last  = (i == lastpos);
            in_cout  = (i == 3) ? c : ~c;
            in_sub   = (i == 0) ? sb : ~sb;
            in_sign  = (i == 0) ? sg : ~sg;
            tick();
        end
        in_valid = 0;
        in_last  = 0;
    endtask
    task automatic expect_out(input string tag, input logic [15:0] mag, input logic sg, input logic ov,
                              input logic er, input int hold);
        repeat (3) tick();
        check({tag, "_early"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_mag"}, out_mag, mag);
        check({tag, "_sign"}, out_sign, sg);
        check({tag, "_ovf"}, out_ovf, ov);
        check({tag, "_err"}, out_err, er);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold"}, {in_ready, out_valid, out_mag, out_sign, out_ovf, out_err}, {1'b0, 1'b1, mag, sg, ov, er});
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        check({tag, "_drop"}, out_valid, 0);
        check({tag, "_rdy"}, in_ready, 1);
    endtask
    initial begin
        repeat (2) tick();
        check("rst_valid", out_valid, 0);
        check("rst_rdy", in_ready, 0);
        check("rst_outs", {out_mag, out_sign, out_ovf, out_err}, 0);
        rst = 0;
        tick();
        check("post_rst_rdy", in_ready, 1);
        send(16'h0374, 1, 1, 0, 3);
        expect_out("sub_cy", 16'h0375, 0, 0, 0, 0);
        send(16'h9624, 0, 1, 0, 3);
        expect_out("sub_nocy", 16'h0375, 1, 0, 0, 0);
        send(16'h9999, 0, 1, 0, 3);
`ifdef BCD_FIX_ZERO_CLEAN_EN
        expect_out("zero", 16'h0000, 0, 0, 0, 0);
`else
        expect_out("zero", 16'h0000, 1, 0, 0, 0);
`endif
        send(16'h1000, 1, 0, 1, 3);
        expect_out("add_ovf", 16'h1000, 1, 1, 0, 5);
        send(16'h0374, 1, 1, 0, 1);
        expect_out("frame", 16'h0375, 0, 0, 1, 0);
        send(16'h0399, 1, 1, 0, 3);
        expect_out("ripple", 16'h0400, 0, 0, 0, 0);
        send(16'h0374, 1, 1, 0, 3);
        repeat (2) tick();
        rst = 1;
        tick();
        rst = 0;
        check("midfix_valid", out_valid, 0);
        check("midfix_outs", {in_ready, out_mag, out_sign, out_ovf, out_err}, 0);
        tick();
        check("midfix_rdy", in_ready, 1);
        send(16'h0374, 1, 1, 0, 3);
        expect_out("after_rst", 16'h0375, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd_result_fix.md
# bcd_result_fix

Digit-serial post-processing stage placed directly downstream of the signed one-digit BCD add/subtract stage. It collects one packet of `DIGITS` sum digits, LSD first, plus the final carry. It then applies the 9's-complement end-around correction: on carry it adds 1; with no carry it takes the 9's complement and flips the sign. The corrected sign-magnitude result is presented on a valid/ready output port.

## Interface
- `DIGITS`, default 4: BCD digits per packet (≥2).
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: digit beat valid.
- `in_ready` out 1: block accepts a beat (transfer = `in_valid & in_ready`).
- `in_digit` in 4: sum digit S from the add/sub stage.
- `in_cout` in 1: digit carry; only the value on the final beat is used.
- `in_last` in 1: marks the final beat; framing check only.
- `in_sub` in 1: effective subtraction (operand signs differ); sampled on the first beat.
- `in_sign` in 1: sign of the non-complemented operand; sampled on the first beat.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_mag` out 4*DIGITS: corrected magnitude, digit 0 in bits [3:0].
- `out_sign` out 1: result sign (1 = negative).
- `out_ovf` out 1: addition overflow (carry out when `in_sub`=0).
- `out_err` out 1: framing error on this packet.

## Operation
- States: COLLECT, FIX, OUT.
- **COLLECT**
  - `in_ready`=1.
  - Each transfer writes `in_digit` into buffer slot `cnt` and increments `cnt`.
  - The transfer at `cnt`=DIGITS-1 also latches `in_cout` into `cy`, then moves to FIX with `cnt`=0.
  - `out_err` is set if `in_last` is 1 on any beat other than the last, or 0 on the last beat. The packet length is always DIGITS beats.
- **FIX**
  - `in_ready`=0. Processes slot `cnt`, one digit per cycle, for DIGITS cycles.
  - `in_sub`=1, `cy`=1: ripple increment with `inc` initialised to 1. Digit 9+1 → 0 with `inc` kept at 1; otherwise d+inc with `inc` cleared. The increment cannot overflow. Sign = `in_sign`.
  - `in_sub`=1, `cy`=0: digit → 9-d. Sign = ~`in_sign`.
  - `in_sub`=0: digits unchanged; sign = `in_sign`; `out_ovf` = `cy`.
  - Non-BCD input digits (>9) are not checked; their result is unspecified.
  - After the last digit, go to OUT.
- **OUT**
  - `out_valid`=1; all outputs held stable until `out_ready`=1.
  - On the handshake, go to COLLECT; clear `cnt`, `out_err`, `out_ovf`.
- Reset (any state, including mid-FIX or mid-OUT):
  - state → COLLECT, `cnt`=0, buffer cleared.
  - `out_valid`=0, `out_mag`=0, `out_sign`=0, `out_ovf`=0, `out_err`=0, `in_ready`=0 during reset.
  - Any partial packet is discarded.

## Timing
- `in_ready` is 1 in the first cycle after `rst` deasserts.
- Accepting the final beat at edge E puts FIX in cycles E..E+DIGITS-1. `out_valid` is 1 after edge E+DIGITS. Latency is fixed at DIGITS cycles, independent of data.
- An OUT handshake at edge H gives `in_ready`=1 after H. A new packet's first beat can be accepted at edge H+1.
- No input/output overlap: at most one packet in flight.
- `in_ready` is registered; it does not depend combinationally on `in_valid`. `out_valid` does not depend on `out_ready`.

## Configuration
- `BCD_FIX_ZERO_CLEAN_EN` defined:
  - If the final magnitude is all zero, `out_sign` is forced to 0.
  - Example: X-X gives sum all 9s, no carry, magnitude 0, sign +.
  - The check is done on the last FIX cycle, with no added latency.
- Not defined: `out_sign` is the computed sign unchanged, so negative zero can appear.

## Test plan
- DIGITS=4, `in_sub`=1, `in_sign`=0, digits 4,7,3,0 (sum 0374), last `in_cout`=1 → `out_mag`=0375, `out_sign`=0, `out_ovf`=0. `out_valid` rises 4 cycles after the last beat.
- `in_sub`=1, `in_sign`=0, sum 9624 (digits 4,2,6,9), `in_cout`=0 → `out_mag`=0375, `out_sign`=1.
- `in_sub`=1, `in_sign`=0, sum 9999, `in_cout`=0 → `out_mag`=0000. With `BCD_FIX_ZERO_CLEAN_EN`, `out_sign`=0; without it, `out_sign`=1.
- `in_sub`=0, `in_sign`=1, sum 1000, `in_cout`=1 → `out_mag`=1000, `out_sign`=1, `out_ovf`=1. Also: hold `out_ready`=0 for 5 cycles → outputs stable and `in_ready`=0 throughout.
- `in_last` asserted on beat 2 of 4 → packet still takes 4 beats and `out_err`=1. The next clean packet gives `out_err`=0.
- Assert `rst` for 1 cycle during FIX → `out_valid`=0 and all outputs 0. The next packet (sum 0374, carry 1, `in_sub`=1) gives 0375 with no corruption.
